// File: rtl/fetch_pkg.sv
// Shared types and defaults for the fetch-stage sequencer.
package fetch_pkg;

    localparam int PC_W    = 32;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [PC_W-1:0] DEFAULT_PC_STEP  = 32'd4;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } fetch_state_e;

    // Instruction addresses are word aligned; the low two bits never leave the stage.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return pc & ~(PC_W'(3));
    endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, runs one imem request at a time and
// hands instructions to decode, squashing responses made stale by redirects.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [PC_W-1:0] PC_STEP  = DEFAULT_PC_STEP
) (
    input  logic               CLK,
    input  logic               RSTN,
    output logic               IMEM_REQ,
    output logic [PC_W-1:0]    IMEM_ADDR,
    input  logic               IMEM_GNT,
    input  logic               IMEM_RVALID,
    input  logic [INSTR_W-1:0] IMEM_RDATA,
    input  logic               REDIRECT,
    input  logic [PC_W-1:0]    REDIRECT_PC,
    output logic [PC_W-1:0]    PC,
    output logic [INSTR_W-1:0] INSTR,
    output logic               VALID,
    output logic               STALLED,
    input  logic               NEXT_STALLED
);

    fetch_state_e       r_state;
    logic [PC_W-1:0]    r_fpc;
    logic [PC_W-1:0]    r_rpc;
    logic               r_drop;
    logic               r_req;
    logic               r_stalled;
    logic               r_valid;
    logic [PC_W-1:0]    r_pc;
    logic [INSTR_W-1:0] r_instr;

    fetch_state_e       w_next_state;
    logic [PC_W-1:0]    w_next_fpc;
    logic               w_next_drop;
    logic               w_load;
    logic               w_gnt;
    logic               w_rsp;
    logic [PC_W-1:0]    w_redirect_pc;

    // Grants and responses arriving in the wrong state are protocol errors and are ignored.
    assign w_gnt         = IMEM_GNT && r_req && (r_state == FETCH);
    assign w_rsp         = IMEM_RVALID && (r_state == WAIT);
    assign w_redirect_pc = align_pc(REDIRECT_PC);

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_next_fpc   = r_fpc;
        w_next_drop  = r_drop;
        w_load       = 1'b0;
        unique case (r_state)
            FETCH: begin
                if (REDIRECT) begin
                    w_next_fpc = w_redirect_pc;
                    if (w_gnt) begin
                        // Old address already went out; its response must be squashed.
                        w_next_state = WAIT;
                        w_next_drop  = 1'b1;
                    end
                end else if (w_gnt) begin
                    w_next_state = WAIT;
                end
            end
            WAIT: begin
                if (REDIRECT) begin
                    w_next_fpc = w_redirect_pc;
                    if (w_rsp) begin
                        w_next_state = FETCH;
                        w_next_drop  = 1'b0;
                    end else begin
                        w_next_drop  = 1'b1;
                    end
                end else if (w_rsp) begin
                    if (r_drop) begin
                        w_next_state = FETCH;
                        w_next_drop  = 1'b0;
                    end else begin
                        w_load       = 1'b1;
                        w_next_fpc   = r_rpc + PC_STEP;
                        w_next_state = NEXT_STALLED ? HOLD : FETCH;
                    end
                end
            end
            HOLD: begin
                if (REDIRECT) begin
                    w_next_fpc   = w_redirect_pc;
                    w_next_state = FETCH;
                end else if (!NEXT_STALLED) begin
                    w_next_state = FETCH;
                end
            end
            default: w_next_state = FETCH;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK) begin
        // NOTE: reset is synchronous; every register here, including the data holding registers, is cleared.
        if (RSTN) begin
            r_state   <= FETCH;
            r_fpc     <= align_pc(RESET_PC);
            r_rpc     <= '0;
            r_drop    <= 1'b0;
            r_req     <= 1'b0;
            r_stalled <= 1'b0;
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_instr   <= '0;
        end else begin
            r_state   <= w_next_state;
            r_fpc     <= w_next_fpc;
            r_drop    <= w_next_drop;
            r_req     <= (w_next_state == FETCH);
            r_stalled <= (w_next_state == WAIT) || (w_next_state == HOLD);
            if (w_gnt) begin
                r_rpc <= r_fpc;
            end
            if (w_load) begin
                r_pc    <= r_rpc;
                r_instr <= IMEM_RDATA;
            end
            // A consumed entry drops VALID unless a fresh response replaces it.
            if (REDIRECT) begin
                r_valid <= 1'b0;
            end else if (w_load) begin
                r_valid <= 1'b1;
            end else if (!NEXT_STALLED) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign IMEM_REQ  = r_req;
    assign IMEM_ADDR = r_req ? r_fpc : '0;
    assign PC        = r_pc;
    assign INSTR     = r_instr;
    assign VALID     = r_valid;
    assign STALLED   = r_stalled;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: sequential fetch, decode stall, redirects, PC wrap and mid-request reset.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        gnt, rvalid, redirect, nstall;
    logic [31:0] rdata, redirect_pc;
    logic        imem_req, valid, stalled;
    logic [31:0] imem_addr, pc, instr;

    logic        gnt_w, rvalid_w;
    logic [31:0] rdata_w;
    logic        imem_req_w, valid_w, stalled_w;
    logic [31:0] imem_addr_w, pc_w, instr_w;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_ctrl dut (
        .CLK(clk), .RSTN(rstn),
        .IMEM_REQ(imem_req), .IMEM_ADDR(imem_addr), .IMEM_GNT(gnt),
        .IMEM_RVALID(rvalid), .IMEM_RDATA(rdata),
        .REDIRECT(redirect), .REDIRECT_PC(redirect_pc),
        .PC(pc), .INSTR(instr), .VALID(valid), .STALLED(stalled),
        .NEXT_STALLED(nstall)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
        .CLK(clk), .RSTN(rstn),
        .IMEM_REQ(imem_req_w), .IMEM_ADDR(imem_addr_w), .IMEM_GNT(gnt_w),
        .IMEM_RVALID(rvalid_w), .IMEM_RDATA(rdata_w),
        .REDIRECT(1'b0), .REDIRECT_PC(32'h0),
        .PC(pc_w), .INSTR(instr_w), .VALID(valid_w), .STALLED(stalled_w),
        .NEXT_STALLED(1'b0)
    );

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Outputs are sampled and inputs changed 1 ns after the active edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b1; gnt = 1'b0; rvalid = 1'b0; rdata = '0;
        redirect = 1'b0; redirect_pc = '0; nstall = 1'b0;
        gnt_w = 1'b0; rvalid_w = 1'b0; rdata_w = '0;
        #2;
        step();
        check("rst_req",     32'(imem_req), 32'd0);
        check("rst_valid",   32'(valid),    32'd0);
        check("rst_stalled", 32'(stalled),  32'd0);
        check("rst_pc",      pc,            32'd0);
        check("rst_instr",   instr,         32'd0);
        rstn = 1'b0;
        gnt  = 1'b1;
        step();

        // Sequential fetch with a permanent grant; extra grants in WAIT are ignored.
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'(i * 4);
            check("seq_req",  32'(imem_req), 32'd1);
            check("seq_addr", imem_addr,     a);
            step();
            check("seq_wait_req",     32'(imem_req), 32'd0);
            check("seq_wait_stalled", 32'(stalled),  32'd1);
            check("seq_wait_valid",   32'(valid),    32'd0);
            rvalid = 1'b1; rdata = instr_of(a);
            step();
            rvalid = 1'b0;
            check("seq_valid", 32'(valid), 32'd1);
            check("seq_pc",    pc,         a);
            check("seq_instr", instr,      instr_of(a));
        end

        // Decode stall at the response for 0x10 holds the entry for 5 cycles.
        step();
        rvalid = 1'b1; rdata = instr_of(32'h10); nstall = 1'b1;
        step();
        rvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("hold_valid",   32'(valid),    32'd1);
            check("hold_pc",      pc,            32'h10);
            check("hold_instr",   instr,         instr_of(32'h10));
            check("hold_req",     32'(imem_req), 32'd0);
            check("hold_stalled", 32'(stalled),  32'd1);
            step();
        end
        nstall = 1'b0;
        check("hold_last_valid", 32'(valid), 32'd1);
        step();
        check("release_valid",   32'(valid),    32'd0);
        check("release_req",     32'(imem_req), 32'd1);
        check("release_addr",    imem_addr,     32'h14);
        check("release_stalled", 32'(stalled),  32'd0);

        // Redirect while waiting on 0x14: that response is dropped.
        step();
        redirect = 1'b1; redirect_pc = 32'h100;
        step();
        redirect = 1'b0;
        check("rdw_stalled", 32'(stalled),  32'd1);
        check("rdw_req",     32'(imem_req), 32'd0);
        rvalid = 1'b1; rdata = instr_of(32'h14);
        step();
        rvalid = 1'b0;
        check("rdw_drop_valid", 32'(valid),    32'd0);
        check("rdw_req2",       32'(imem_req), 32'd1);
        check("rdw_addr",       imem_addr,     32'h100);
        step();
        rvalid = 1'b1; rdata = instr_of(32'h100);
        step();
        rvalid = 1'b0;
        check("rdw_new_valid", 32'(valid), 32'd1);
        check("rdw_new_pc",    pc,         32'h100);
        check("rdw_new_instr", instr,      instr_of(32'h100));

        // Redirect to an unaligned target while in HOLD.
        step();
        rvalid = 1'b1; rdata = instr_of(32'h104); nstall = 1'b1;
        step();
        rvalid = 1'b0;
        check("rdh_pre_valid", 32'(valid), 32'd1);
        check("rdh_pre_pc",    pc,         32'h104);
        redirect = 1'b1; redirect_pc = 32'h203;
        step();
        redirect = 1'b0; nstall = 1'b0;
        check("rdh_valid",   32'(valid),    32'd0);
        check("rdh_req",     32'(imem_req), 32'd1);
        check("rdh_addr",    imem_addr,     32'h200);
        check("rdh_stalled", 32'(stalled),  32'd0);

        // Redirect coincident with the response: discarded, no lingering drop.
        step();
        rvalid = 1'b1; rdata = instr_of(32'h200);
        redirect = 1'b1; redirect_pc = 32'h300;
        step();
        rvalid = 1'b0; redirect = 1'b0;
        check("rdr_valid",   32'(valid),    32'd0);
        check("rdr_req",     32'(imem_req), 32'd1);
        check("rdr_addr",    imem_addr,     32'h300);
        check("rdr_stalled", 32'(stalled),  32'd0);
        step();
        rvalid = 1'b1; rdata = instr_of(32'h300);
        step();
        rvalid = 1'b0;
        check("rdr_new_valid", 32'(valid), 32'd1);
        check("rdr_new_pc",    pc,         32'h300);
        check("rdr_new_instr", instr,      instr_of(32'h300));

        // Redirect in FETCH on the grant cycle: the 0x304 response is squashed.
        redirect = 1'b1; redirect_pc = 32'h400;
        step();
        redirect = 1'b0;
        check("rdg_valid",   32'(valid),   32'd0);
        check("rdg_stalled", 32'(stalled), 32'd1);
        rvalid = 1'b1; rdata = instr_of(32'h304);
        step();
        rvalid = 1'b0; gnt = 1'b0;
        check("rdg_drop_valid", 32'(valid), 32'd0);
        check("rdg_addr",       imem_addr,  32'h400);
        step();
        check("nogrant_req",  32'(imem_req), 32'd1);
        check("nogrant_addr", imem_addr,     32'h400);

        // Wrapping instance: FFFF_FFFC + 4 -> 0, then reset mid-WAIT.
        check("wrap_first_addr", imem_addr_w, 32'hFFFF_FFFC);
        gnt_w = 1'b1;
        step();
        gnt_w = 1'b0; rvalid_w = 1'b1; rdata_w = instr_of(32'hFFFF_FFFC);
        step();
        rvalid_w = 1'b0;
        check("wrap_valid", 32'(valid_w),    32'd1);
        check("wrap_pc",    pc_w,            32'hFFFF_FFFC);
        check("wrap_req",   32'(imem_req_w), 32'd1);
        check("wrap_addr",  imem_addr_w,     32'h0);
        gnt_w = 1'b1;
        step();
        gnt_w = 1'b0;
        check("wrap_wait_stalled", 32'(stalled_w), 32'd1);
        rstn = 1'b1;
        step();
        rstn = 1'b0;
        check("mrst_valid",   32'(valid_w),    32'd0);
        check("mrst_req",     32'(imem_req_w), 32'd0);
        check("mrst_stalled", 32'(stalled_w),  32'd0);
        check("mrst_pc",      pc_w,            32'h0);
        rvalid_w = 1'b1; rdata_w = 32'hBAD0_BAD0;
        step();
        rvalid_w = 1'b0;
        check("late_valid",   32'(valid_w),    32'd0);
        check("late_req",     32'(imem_req_w), 32'd1);
        check("late_addr",    imem_addr_w,     32'hFFFF_FFFC);
        check("late_stalled", 32'(stalled_w),  32'd0);
        check("late_main_addr", imem_addr,     32'h0);
        step();
        check("late_valid2", 32'(valid_w), 32'd0);
        check("late_instr",  instr_w,      32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
